// File: rtl/gray_seq_checker.sv
// Gray-code stream monitor: decodes each accepted codeword, classifies the step from the
// previous one and counts illegal steps. Optional direction check: GSC_DIR_CHECK_EN.
module gray_seq_checker #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             g_valid,
    input  logic [WIDTH-1:0] g_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             step_err,
    output logic             locked,
    output logic [CNT_W-1:0] err_count,
    output logic             dir_err
);

    typedef enum logic [1:0] {IDLE, TRACK, LOST} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] decoded;
    logic [WIDTH-1:0] up_ref;
    logic [WIDTH-1:0] dn_ref;
    logic             bin_valid_reg;
    logic             step_up_reg;
    logic             step_dn_reg;
    logic             step_err_reg;
    logic [CNT_W-1:0] err_count_reg;

    // Binary bit i is the XOR of all Gray bits at or above i.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_decode
            assign decoded[gi] = ^g_in[WIDTH-1:gi];
        end
    endgenerate

    assign up_ref = prev_reg + WIDTH'(1);
    assign dn_ref = prev_reg - WIDTH'(1);

`ifdef GSC_DIR_CHECK_EN
    logic dir_known_reg;
    logic dir_up_reg;
    logic dir_err_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            prev_reg      <= '0;
            bin_valid_reg <= 1'b0;
            step_up_reg   <= 1'b0;
            step_dn_reg   <= 1'b0;
            step_err_reg  <= 1'b0;
            err_count_reg <= '0;
`ifdef GSC_DIR_CHECK_EN
            dir_known_reg <= 1'b0;
            dir_up_reg    <= 1'b0;
            dir_err_reg   <= 1'b0;
`endif
        end else begin
            bin_valid_reg <= g_valid;
            step_up_reg   <= 1'b0;
            step_dn_reg   <= 1'b0;
            step_err_reg  <= 1'b0;
`ifdef GSC_DIR_CHECK_EN
            dir_err_reg   <= 1'b0;
`endif
            if (g_valid) begin
                prev_reg <= decoded;
                case (state_reg)
                    TRACK: begin
                        if (decoded == prev_reg) begin
                            // hold: same codeword repeated, nothing to flag
                        end else if (decoded == up_ref) begin
                            step_up_reg <= 1'b1;
`ifdef GSC_DIR_CHECK_EN
                            if (dir_known_reg && !dir_up_reg)
                                dir_err_reg <= 1'b1;
                            dir_known_reg <= 1'b1;
                            dir_up_reg    <= 1'b1;
`endif
                        end else if (decoded == dn_ref) begin
                            step_dn_reg <= 1'b1;
`ifdef GSC_DIR_CHECK_EN
                            if (dir_known_reg && dir_up_reg)
                                dir_err_reg <= 1'b1;
                            dir_known_reg <= 1'b1;
                            dir_up_reg    <= 1'b0;
`endif
                        end else begin
                            step_err_reg <= 1'b1;
                            state_reg    <= LOST;
                            if (err_count_reg != {CNT_W{1'b1}})
                                err_count_reg <= err_count_reg + CNT_W'(1);
`ifdef GSC_DIR_CHECK_EN
                            dir_known_reg <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        // IDLE or LOST: take the sample as the new reference unchecked
                        state_reg <= TRACK;
`ifdef GSC_DIR_CHECK_EN
                        dir_known_reg <= 1'b0;
`endif
                    end
                endcase
            end
        end
    end

    assign bin_out   = prev_reg;
    assign bin_valid = bin_valid_reg;
    assign step_up   = step_up_reg;
    assign step_dn   = step_dn_reg;
    assign step_err  = step_err_reg;
    assign locked    = (state_reg == TRACK);
    assign err_count = err_count_reg;
`ifdef GSC_DIR_CHECK_EN
    assign dir_err   = dir_err_reg;
`else
    assign dir_err   = 1'b0;
`endif

endmodule

// File: tb/tb_gray_seq_checker.sv
// Self-checking bench for gray_seq_checker (WIDTH=3, CNT_W=8): directed scenarios plus
// randomized traffic compared against a step-arithmetic reference model.
module tb_gray_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       g_valid = 1'b0;
    logic [2:0] g_in = 3'd0;
    logic [2:0] bin_out;
    logic       bin_valid, step_up, step_dn, step_err, locked, dir_err;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_mode = 0;   // 0 = no reference, 1 = tracking, 2 = lost
    int m_prev = 0;
    int m_cnt  = 0;
    int m_dir  = 0;   // 0 unknown, 1 up, -1 down
    int m_valid = 0, m_up = 0, m_dn = 0, m_err = 0, m_dirr = 0;

    gray_seq_checker dut (
        .clk(clk), .rst(rst), .g_valid(g_valid), .g_in(g_in),
        .bin_out(bin_out), .bin_valid(bin_valid), .step_up(step_up),
        .step_dn(step_dn), .step_err(step_err), .locked(locked),
        .err_count(err_count), .dir_err(dir_err)
    );

    always #5 clk = ~clk;

    function automatic int gray_to_bin(input int g);
        for (int i = 0; i < 8; i++)
            if ((i ^ (i >> 1)) == g) return i;
        return -1;
    endfunction

    function automatic logic [2:0] bin_to_gray(input int b);
        return 3'(b ^ (b >> 1));
    endfunction

    // Drive one cycle, then advance the model by the same input.
    task automatic cyc(input logic r, input logic v, input logic [2:0] g);
        int n, d;
        rst = r; g_valid = v; g_in = g;
        @(posedge clk);
        #1;
        m_valid = 0; m_up = 0; m_dn = 0; m_err = 0; m_dirr = 0;
        if (r) begin
            m_mode = 0; m_prev = 0; m_cnt = 0; m_dir = 0;
        end else if (v) begin
            n = gray_to_bin(int'(g));
            m_valid = 1;
            if (m_mode != 1) begin
                m_mode = 1; m_dir = 0;
            end else begin
                d = (n - m_prev + 8) % 8;
                if (d == 1 || d == 7) begin
                    if (d == 1) m_up = 1; else m_dn = 1;
`ifdef GSC_DIR_CHECK_EN
                    if (m_dir != 0 && m_dir != (d == 1 ? 1 : -1)) m_dirr = 1;
                    m_dir = (d == 1) ? 1 : -1;
`endif
                end else if (d != 0) begin
                    m_err = 1; m_mode = 2; m_dir = 0;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            m_prev = n;
        end
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b1, 3'b011);
        cyc(1'b1, 1'b0, 3'b000);
        n_tests++;
        if ({bin_out, bin_valid, step_up, step_dn, step_err, locked, dir_err} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0", {bin_out, bin_valid, step_up, step_dn, step_err, locked, dir_err});
        end
        n_tests++;
        if (err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d required 0", err_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_count_sequence();
        logic [2:0] seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, seq[i]);
            n_tests++;
            if (bin_out !== 3'(i) || bin_valid !== 1'b1 || step_up !== (i > 0) ||
                step_dn !== 1'b0 || step_err !== 1'b0 || locked !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_%0d: got bin=%0d v=%b up=%b dn=%b err=%b lk=%b required bin=%0d v=1 up=%b dn=0 err=0 lk=1",
                         i, bin_out, bin_valid, step_up, step_dn, step_err, locked, i, (i > 0));
            end
        end
    endtask

    task automatic test_wrap();
        cyc(1'b0, 1'b1, 3'b000);
        n_tests++;
        if (bin_out !== 3'd0 || step_up !== 1'b1 || step_dn !== 1'b0 || step_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_up: got bin=%0d up=%b dn=%b err=%b required bin=0 up=1", bin_out, step_up, step_dn, step_err);
        end
        cyc(1'b0, 1'b1, 3'b100);
        n_tests++;
        if (bin_out !== 3'd7 || step_dn !== 1'b1 || step_up !== 1'b0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_dn: got bin=%0d dn=%b up=%b cnt=%0d required bin=7 dn=1 cnt=0", bin_out, step_dn, step_up, err_count);
        end
    endtask

    task automatic test_illegal();
        cyc(1'b1, 1'b0, 3'b000);
        cyc(1'b0, 1'b1, 3'b000);
        cyc(1'b0, 1'b1, 3'b001);
        cyc(1'b0, 1'b1, 3'b101);
        n_tests++;
        if (bin_out !== 3'd6 || step_err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_step: got bin=%0d err=%b cnt=%0d lk=%b required bin=6 err=1 cnt=1 lk=0", bin_out, step_err, err_count, locked);
        end
        cyc(1'b0, 1'b1, 3'b111);
        n_tests++;
        if (bin_out !== 3'd5 || bin_valid !== 1'b1 || {step_up, step_dn, step_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL lost_reload: got bin=%0d v=%b flags=%b required bin=5 v=1 flags=000", bin_out, bin_valid, {step_up, step_dn, step_err});
        end
        cyc(1'b0, 1'b1, 3'b110);
        n_tests++;
        if (bin_out !== 3'd4 || step_dn !== 1'b1 || locked !== 1'b1 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL relock_dn: got bin=%0d dn=%b lk=%b cnt=%0d required bin=4 dn=1 lk=1 cnt=1", bin_out, step_dn, locked, err_count);
        end
    endtask

    task automatic test_hold_gap();
        cyc(1'b1, 1'b0, 3'b000);
        cyc(1'b0, 1'b1, 3'b011);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 3'($urandom_range(0, 7)));
            n_tests++;
            if (bin_valid !== 1'b0 || bin_out !== 3'd2 || {step_up, step_dn, step_err} !== 3'b000 || locked !== 1'b1) begin
                n_fail++;
                $display("FAIL gap_%0d: got v=%b bin=%0d flags=%b lk=%b required v=0 bin=2 flags=000 lk=1", i, bin_valid, bin_out, {step_up, step_dn, step_err}, locked);
            end
        end
        cyc(1'b0, 1'b1, 3'b011);
        n_tests++;
        if (bin_valid !== 1'b1 || bin_out !== 3'd2 || {step_up, step_dn, step_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL hold: got v=%b bin=%0d flags=%b required v=1 bin=2 flags=000", bin_valid, bin_out, {step_up, step_dn, step_err});
        end
    endtask

    task automatic test_reset_priority();
        cyc(1'b1, 1'b0, 3'b000);
        cyc(1'b0, 1'b1, 3'b000);
        cyc(1'b0, 1'b1, 3'b001);
        cyc(1'b1, 1'b1, 3'b011);
        n_tests++;
        if (bin_out !== 3'd0 || bin_valid !== 1'b0 || step_up !== 1'b0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_priority: got bin=%0d v=%b up=%b lk=%b required all 0", bin_out, bin_valid, step_up, locked);
        end
        cyc(1'b0, 1'b1, 3'b011);
        n_tests++;
        if (bin_out !== 3'd2 || bin_valid !== 1'b1 || step_up !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL post_rst_load: got bin=%0d v=%b up=%b lk=%b required bin=2 v=1 up=0 lk=1", bin_out, bin_valid, step_up, locked);
        end
    endtask

    task automatic test_dir();
        int seq [4] = '{0, 1, 2, 1};
        logic want;
        cyc(1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, bin_to_gray(seq[i]));
`ifdef GSC_DIR_CHECK_EN
            want = (i == 3);
`else
            want = 1'b0;
`endif
            n_tests++;
            if (dir_err !== want) begin
                n_fail++;
                $display("FAIL dir_%0d: got %b required %b", i, dir_err, want);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] g;
        int bad = 0;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: g = 3'($urandom_range(0, 7));
                1: g = bin_to_gray((m_prev + 1) % 8);
                2: g = bin_to_gray((m_prev + 7) % 8);
                default: g = bin_to_gray(m_prev);
            endcase
            cyc(1'b0 ? 1'b0 : ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), g);
            n_tests++;
            if (bin_out !== 3'(m_prev) || bin_valid !== 1'(m_valid) || step_up !== 1'(m_up) ||
                step_dn !== 1'(m_dn) || step_err !== 1'(m_err) || locked !== (m_mode == 1) ||
                err_count !== 8'(m_cnt) || dir_err !== 1'(m_dirr)) begin
                n_fail++;
                if (bad++ < 10)
                    $display("FAIL random_%0d: got bin=%0d v=%b up=%b dn=%b err=%b lk=%b cnt=%0d dir=%b required bin=%0d v=%0d up=%0d dn=%0d err=%0d lk=%0d cnt=%0d dir=%0d",
                             i, bin_out, bin_valid, step_up, step_dn, step_err, locked, err_count, dir_err,
                             m_prev, m_valid, m_up, m_dn, m_err, (m_mode == 1), m_cnt, m_dirr);
            end
        end
    endtask

    task automatic test_saturation();
        cyc(1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 560; i++) begin
            cyc(1'b0, 1'b1, (i % 2 == 0) ? 3'b000 : 3'b010);
            if (err_count !== 8'(m_cnt)) begin
                n_tests++;
                n_fail++;
                $display("FAIL sat_track_%0d: got %0d required %0d", i, err_count, m_cnt);
            end
        end
        n_tests++;
        if (err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL saturate: got %0d required 255", err_count);
        end
        cyc(1'b0, 1'b1, 3'b000);
        cyc(1'b0, 1'b1, 3'b010);
        n_tests++;
        if (err_count !== 8'd255 || step_err !== 1'b1) begin
            n_fail++;
            $display("FAIL no_wrap: got cnt=%0d err=%b required cnt=255 err=1", err_count, step_err);
        end
        cyc(1'b1, 1'b0, 3'b000);
        n_tests++;
        if ({bin_out, bin_valid, step_up, step_dn, step_err, locked, dir_err} !== 9'd0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL sat_reset: got outs=%b cnt=%0d required 0", {bin_out, bin_valid, step_up, step_dn, step_err, locked, dir_err}, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_count_sequence();
        test_wrap();
        test_illegal();
        test_hold_gap();
        test_reset_priority();
        test_dir();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
